// File: rtl/pattern_gen_if.sv
// pattern_gen_if: request inputs and serial-stream outputs of the pattern generator
interface pattern_gen_if;
    logic       start;
    logic [7:0] data;
    logic [2:0] len;
    logic [1:0] reps;
    logic       x;
    logic       x_valid;
    logic       busy;
    logic       done;
    logic [3:0] fall_cnt;
    modport master (output start, data, len, reps, input x, x_valid, busy, done, fall_cnt);
    modport slave  (input start, data, len, reps, output x, x_valid, busy, done, fall_cnt);
endinterface

// File: rtl/pattern_gen.sv
// pattern_gen: serialises data[len:0] MSB-first reps+1 times with one-cycle gaps, counting 1->0 falls
module pattern_gen (
    input logic          clk,
    input logic          rst,
    pattern_gen_if.slave bus_if
);
    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
    state_t     state_q;
    logic [7:0] data_q;
    logic [2:0] len_q, idx_q, idx_d;
    logic [1:0] reps_q;
    logic       prev_q, x_q, xv_q, busy_q, done_q, bit_d;
    logic [3:0] fall_q, fall_d;
    logic [7:0] src_d;
    // Next emitted bit and its fall count; on accept the live inputs are used and history starts cleared
    always_comb begin
        src_d  = (state_q == IDLE) ? bus_if.data : data_q;
        idx_d  = (state_q == IDLE) ? bus_if.len : (state_q == GAP) ? len_q : idx_q - 3'd1;
        bit_d  = src_d[idx_d];
        fall_d = (state_q == IDLE) ? 4'd0 :
                 (prev_q && !bit_d && fall_q != 4'd15) ? fall_q + 4'd1 : fall_q;
    end
    // FSM with all outputs registered so they depend on state only
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            len_q   <= '0;
            reps_q  <= '0;
            idx_q   <= '0;
            prev_q  <= 1'b0;
            x_q     <= 1'b0;
            xv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fall_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus_if.start) begin
                    data_q  <= bus_if.data;
                    len_q   <= bus_if.len;
                    reps_q  <= bus_if.reps;
                    idx_q   <= idx_d;
                    prev_q  <= bit_d;
                    x_q     <= bit_d;
                    xv_q    <= 1'b1;
                    busy_q  <= 1'b1;
                    fall_q  <= fall_d;
                    state_q <= SEND;
                end
                SEND: if (idx_q != 3'd0) begin
                    idx_q  <= idx_d;
                    prev_q <= bit_d;
                    x_q    <= bit_d;
                    fall_q <= fall_d;
                end else begin
                    x_q     <= 1'b0;
                    xv_q    <= 1'b0;
                    done_q  <= (reps_q == 2'd0);
                    state_q <= (reps_q != 2'd0) ? GAP : DONE;
                end
                GAP: begin
                    reps_q  <= reps_q - 2'd1;
                    idx_q   <= idx_d;
                    prev_q  <= bit_d;
                    x_q     <= bit_d;
                    xv_q    <= 1'b1;
                    fall_q  <= fall_d;
                    state_q <= SEND;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus_if.x        = x_q;
    assign bus_if.x_valid  = xv_q;
    assign bus_if.busy     = busy_q;
    assign bus_if.done     = done_q;
    assign bus_if.fall_cnt = fall_q;
endmodule

// File: doc/pattern_gen.md
PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port start, input, 1 bit: request to begin a transmission; sampled only in IDLE.
REQ-004 The block SHALL have the port data, input, 8 bits: pattern source; sampled on the start-accept edge.
REQ-005 The block SHALL have the port len, input, 3 bits: the number of bits per repetition is len+1 (1..8); sampled on the start-accept edge.
REQ-006 The block SHALL have the port reps, input, 2 bits: the number of repetitions is reps+1 (1..4); sampled on the start-accept edge.
REQ-007 The block SHALL have the port x, output, 1 bit: registered serial bit stream.
REQ-008 The block SHALL have the port x_valid, output, 1 bit: registered; high when x carries a pattern bit.
REQ-009 The block SHALL have the port busy, output, 1 bit: registered; high in every state except IDLE.
REQ-010 The block SHALL have the port done, output, 1 bit: registered; one-cycle pulse at the end of a transmission.
REQ-011 The block SHALL have the port fall_cnt, output, 4 bits: registered, saturating count of 1->0 transitions in the emitted valid bits.

Function
REQ-012 The block SHALL implement a Moore FSM with the states IDLE, SEND, GAP and DONE, and all outputs SHALL be functions of registered state only.
REQ-013 In IDLE, start=1 at a rising edge SHALL be accepted: data, len and reps are latched, the bit index is set to len, the repetition counter is set to reps, fall_cnt is cleared, the previous-bit register is cleared, and the FSM moves to SEND.
REQ-014 The first bit SHALL appear on x with x_valid=1 in the cycle immediately after the accept edge (latency 1).
REQ-015 In SEND, bits SHALL be emitted MSB-first, data[len] down to data[0], at one bit per cycle.
REQ-016 After data[0] is emitted in SEND, the FSM SHALL move to GAP if the remaining repetitions are greater than 0, and otherwise to DONE.
REQ-017 GAP SHALL last exactly one cycle with x=0 and x_valid=0, SHALL decrement the repetition counter, SHALL reload the bit index to the latched len, and SHALL then return to SEND.
REQ-018 DONE SHALL last exactly one cycle with done=1, busy=1 and x_valid=0, after which the FSM returns to IDLE.
REQ-019 The total number of busy cycles SHALL be (len+1)*(reps+1) + reps + 1.
REQ-020 fall_cnt SHALL increment whenever the emitted valid bit is 0 and the previous valid bit was 1.
REQ-021 GAP cycles SHALL be ignored for fall_cnt: the previous-bit register is not updated or cleared in GAP.
REQ-022 The previous-bit register SHALL start at 0 on the accept edge, so a leading 0 bit does not count as a transition.
REQ-023 fall_cnt SHALL saturate at 15 and SHALL hold its value after DONE until the next accepted start.
REQ-024 start SHALL be ignored in SEND, GAP and DONE, and latched values SHALL NOT change during a transmission.
REQ-025 Changes on data, len and reps after the accept edge SHALL have no effect on the transmission in progress.
REQ-026 x SHALL be 0 whenever x_valid is 0.

Reset
REQ-027 rst=1 at a rising edge SHALL force the FSM to IDLE and SHALL set x, x_valid, busy, done and fall_cnt to 0 in the following cycle.
REQ-028 Reset SHALL take priority over start and over any in-progress transmission (abort mid-SEND or mid-GAP); no done pulse SHALL be produced for an aborted transmission.
REQ-029 start=1 in the first cycle after rst is released SHALL be accepted normally.

Verification
REQ-030 Scenario: data=0xA6, len=7, reps=0, start pulse -> x=1,0,1,0,0,1,1,0 with x_valid=1 for 8 cycles; done pulses in cycle 9; fall_cnt=3.
REQ-031 Scenario: data=0x01, len=0, reps=3 -> x_valid pattern 1,0,1,0,1,0,1 with x=1 on every valid cycle; then done; fall_cnt=0; busy high for 8 cycles.
REQ-032 Scenario: data=0x02, len=1, reps=1 -> valid bits 1,0 / gap / 1,0; fall_cnt=2; done in cycle 6.
REQ-033 Scenario: data=0xAA, len=7, reps=3 -> 4 falls per repetition (16 total); fall_cnt saturates at 15; done after 36 cycles.
REQ-034 Scenario: start re-asserted with different data mid-SEND -> the stream is unchanged and exactly one done pulse is produced.
REQ-035 Scenario: rst asserted in the 3rd SEND cycle -> the next cycle shows all outputs 0 and no done pulse; a start 1 cycle after release transmits the new pattern correctly.
